pwm_compare_stage: RTL and testbench
====================================

Name: pwm_compare_stage

Overview:
- Downstream consumer of the free-running mod-N counter. Compares the counter value against a double-buffered duty value and produces a registered PWM output plus a once-per-period pulse.
- New duty values enter through a valid/ready handshake. They are held in a pending register and applied only at a period boundary, so no period is ever glitched or truncated.

Parameters:
- N, 6, counter modulus; period length in clk cycles. Range 2..2^LENGTH.
- LENGTH, 3, width of the counter value input.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- count  input  LENGTH  counter value from the mod-N counter; advances 0..N-1 once per clk.
- duty_in  input  LENGTH+1  requested high-time in cycles (0..N).
- duty_valid  input  1  duty_in is valid this cycle.
- duty_ready  output  1  block can accept a duty value this cycle.
- pwm_out  output  1  registered PWM output.
- period_done  output  1  one-cycle pulse marking the start of a new period.
- active_duty  output  LENGTH+1  duty value currently in effect (observability).

Behaviour:
- Reset (async, rst=1): pwm_out=0, period_done=0, active_duty=0, pending register=0, pending_full=0, so duty_ready=1. Reset asserted mid-operation discards any pending value immediately.
- Boundary: boundary = (count == N-1) sampled at a rising edge. A count value of N or above is never a boundary. Its compare result is still computed normally.
- Clamp: any duty_in greater than N is clamped to N on acceptance.
- Handshake:
  - duty_ready = !pending_full (combinational from state).
  - Accept occurs when duty_valid && duty_ready at the clk edge.
  - duty_in is don't-care when duty_valid=0.
  - A held duty_valid with duty_ready=0 is not accepted and is not lost; the bench/source must hold it.
- Shadow update at each clk edge, evaluated in this priority:
  - 1. Boundary and pending_full: active_duty <= pending; pending_full <= 0. A simultaneous accept is impossible because duty_ready=0.
  - 2. Boundary, pending empty, accept: active_duty <= clamp(duty_in) directly (bypass); pending_full stays 0.
  - 3. No boundary, accept: pending <= clamp(duty_in); pending_full <= 1.
  - 4. Otherwise: hold.
- PWM: pwm_out <= (count < active_duty), using the active_duty value before the edge's update.
  - Latency is 1 cycle from count to pwm_out.
  - A duty loaded at the N-1 boundary governs compares starting at count=0.
  - duty=0 gives pwm_out constantly 0; duty=N gives constantly 1 (no glitch at wrap).
- period_done <= boundary. It is high exactly during the cycle in which count=0 is presented, once every N cycles.
- All arithmetic is unsigned. The compare zero-extends count to LENGTH+1 bits.

Test Plan (N=6, LENGTH=3):
- Release reset, never assert duty_valid -> pwm_out=0 always; period_done high every 6th cycle (count=0 cycles); duty_ready=1; active_duty=0.
- Assert duty_valid with duty_in=2 while count=3:
  - duty_ready drops to 0 the next cycle.
  - active_duty becomes 2 after the count=5 edge; duty_ready returns to 1.
  - pwm_out is high exactly 2 cycles per period, in the cycles following count=0 and count=1.
- Load duty_in=6 -> pwm_out held 1 continuously across wraps. Load duty_in=9 -> active_duty=6 (clamped). Load duty_in=0 -> pwm_out held 0 from the next period.
- Back-pressure:
  - Load 3 at count=1, then hold duty_valid with duty_in=4 from count=2.
  - duty_ready stays 0 until the count=5 edge, when active_duty=3.
  - duty_in=4 is accepted on the next edge (count=0, no boundary) into pending.
  - active_duty=4 is applied at the following count=5 edge.
- Bypass: with pending empty, present duty_in=5 with duty_valid only in the cycle count=5 -> duty_ready stays 1; active_duty=5 immediately; pwm_out high 5 cycles in the next period.
- Reset mid-period with pending_full=1 (pending=4, active=2) -> all outputs return to reset values asynchronously. After release, pending is gone: active_duty=0 and pwm_out=0 until a new load.

Source files
------------

// File: rtl/pwm_compare_stage_if.sv
// Duty handshake, counter input and PWM outputs of pwm_compare_stage.
//   master: counter/duty source. It drives count, duty_in and duty_valid.
//   slave : compare stage. It drives duty_ready, pwm_out, period_done and active_duty.
interface pwm_compare_stage_if #(
    parameter int unsigned LENGTH = 3
);
    logic [LENGTH-1:0] count;
    logic [LENGTH:0]   duty_in;
    logic              duty_valid;
    logic              duty_ready;
    logic              pwm_out;
    logic              period_done;
    logic [LENGTH:0]   active_duty;

    modport master (
        output count, duty_in, duty_valid,
        input  duty_ready, pwm_out, period_done, active_duty
    );

    modport slave (
        input  count, duty_in, duty_valid,
        output duty_ready, pwm_out, period_done, active_duty
    );
endinterface

// File: rtl/pwm_compare_stage.sv
// PWM compare stage with a double-buffered duty value.
// It compares the free-running mod-N count against the active duty and registers the PWM
// output. A new duty waits in a pending register and takes effect only at a period boundary.
// When the boundary itself accepts a duty and nothing is pending, the new duty applies
// directly.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - slave modport:
//            count, duty_in, duty_valid -> into this block
//            duty_ready, pwm_out, period_done, active_duty <- out of this block
module pwm_compare_stage #(
    parameter int unsigned N      = 6,
    parameter int unsigned LENGTH = 3
) (
    input logic                 clk,
    input logic                 rst,
    pwm_compare_stage_if.slave  bus
);

    localparam logic [LENGTH-1:0] LastCount = LENGTH'(N - 1);
    localparam logic [LENGTH:0]   DutyMax   = (LENGTH + 1)'(N);

    logic [LENGTH:0] active_q, active_d;
    logic [LENGTH:0] pending_q, pending_d;
    logic            pending_full_q, pending_full_d;
    logic            pwm_q, pwm_d;
    logic            period_done_q, period_done_d;

    logic            boundary;
    logic            accept;
    logic [LENGTH:0] duty_clamped;

    always_comb begin
        // A count of N or above never equals N-1, so it is never a boundary.
        boundary     = (bus.count == LastCount);
        accept       = bus.duty_valid && !pending_full_q;
        duty_clamped = (bus.duty_in > DutyMax) ? DutyMax : bus.duty_in;

        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;

        if (boundary && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end else if (boundary && accept) begin
            active_d = duty_clamped;
        end else if (accept) begin
            pending_d      = duty_clamped;
            pending_full_d = 1'b1;
        end

        // The compare uses the duty in effect before this edge's update.
        pwm_d         = ({1'b0, bus.count} < active_q);
        period_done_d = boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            pwm_q          <= 1'b0;
            period_done_q  <= 1'b0;
        end else begin
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            pwm_q          <= pwm_d;
            period_done_q  <= period_done_d;
        end
    end

    assign bus.duty_ready  = !pending_full_q;
    assign bus.pwm_out     = pwm_q;
    assign bus.period_done = period_done_q;
    assign bus.active_duty = active_q;

endmodule

// File: tb/tb_pwm_compare_stage.sv
module tb_pwm_compare_stage;

    localparam int N = 6;
    localparam int LENGTH = 3;

    typedef struct {
        int pwm;
        int pd;
        int act;
        int rdy;
    } exp_t;

    logic clk;
    logic rst;
    pwm_compare_stage_if #(.LENGTH(LENGTH)) bus ();

    pwm_compare_stage #(.N(N), .LENGTH(LENGTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    // Reference model: one active duty plus at most one queued duty.
    int   m_active;
    int   m_pend[$];
    int   m_c;
    int   m_dv;
    bit   m_bnd;
    bit   m_acc;
    exp_t m_e;

    logic [LENGTH-1:0] cnt;
    bit                wild;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    initial begin
        m_active = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 0;
                m_pend.delete();
                exp_q.delete();
            end else begin
                m_c   = int'(bus.count);
                m_bnd = (m_c == N - 1);
                m_acc = bus.duty_valid && (m_pend.size() == 0);
                m_dv  = int'(bus.duty_in);
                if (m_dv > N) m_dv = N;
                m_e.pwm = (m_c < m_active) ? 1 : 0;
                m_e.pd  = m_bnd ? 1 : 0;
                if (m_bnd && m_pend.size() > 0) m_active = m_pend.pop_front();
                else if (m_bnd && m_acc) m_active = m_dv;
                else if (m_acc) m_pend.push_back(m_dv);
                m_e.act = m_active;
                m_e.rdy = (m_pend.size() == 0) ? 1 : 0;
                exp_q.push_back(m_e);
            end
        end
    end

    // Monitor: compares at the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_pwm_out", int'(bus.pwm_out), 0);
                chk("rst_period_done", int'(bus.period_done), 0);
                chk("rst_active_duty", int'(bus.active_duty), 0);
                chk("rst_duty_ready", int'(bus.duty_ready), 1);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pwm_out", int'(bus.pwm_out), e.pwm);
                chk("period_done", int'(bus.period_done), e.pd);
                chk("active_duty", int'(bus.active_duty), e.act);
                chk("duty_ready", int'(bus.duty_ready), e.rdy);
            end
        end
    end

    // Presents one cycle of inputs, then returns 1 ns after the next rising edge.
    task automatic step(input logic v, input logic [LENGTH:0] d, output logic acc);
        logic rdy;
        bus.count      = wild ? LENGTH'($urandom_range(0, 7)) : cnt;
        bus.duty_valid = v;
        bus.duty_in    = d;
        rdy            = bus.duty_ready;
        acc            = v && rdy && !rst;
        @(posedge clk);
        #1;
        cnt = (int'(cnt) == N - 1) ? '0 : cnt + 1'b1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 4'($urandom_range(0, 15)), acc);
    endtask

    task automatic step_until(input int c);
        logic acc;
        for (int i = 0; i < 2 * N && int'(cnt) != c; i++) step(1'b0, '0, acc);
    endtask

    // Holds duty_valid until accepted, with a cycle bound.
    task automatic load(input logic [LENGTH:0] d);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, d, acc);
        n_cmp++;
        if (!acc) begin
            n_bad++;
            $display("FAIL load_accept at %0t: got not accepted, want accepted (duty %0d)",
                     $time, d);
        end
    endtask

    initial begin
        logic             acc;
        logic             hv;
        logic [LENGTH:0]  hd;
        rst            = 1'b0;
        cnt            = '0;
        wild           = 1'b0;
        bus.count      = '0;
        bus.duty_valid = 1'b0;
        bus.duty_in    = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle: pwm stays 0, period_done every N cycles.
        idle(14);

        // Load 2 at count=3.
        step_until(3);
        step(1'b1, 4'd2, acc);
        idle(14);

        // Full duty, clamped duty, zero duty.
        load(4'd6);
        idle(14);
        load(4'd9);
        idle(14);
        load(4'd0);
        idle(14);

        // Back-pressure: 3 at count=1, then 4 held from count=2.
        step_until(1);
        step(1'b1, 4'd3, acc);
        load(4'd4);
        idle(14);

        // Bypass at the boundary cycle.
        step_until(5);
        step(1'b1, 4'd5, acc);
        idle(14);

        // Reset with a pending value.
        step_until(0);
        load(4'd2);
        idle(8);
        step_until(1);
        step(1'b1, 4'd4, acc);
        step(1'b0, '0, acc);
        #3 rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(14);

        // Random traffic with source-held requests and occasional resets.
        hv = 1'b0;
        hd = '0;
        for (int i = 0; i < 3000; i++) begin
            wild = (i >= 2000 && i < 2300);
            if (!hv && $urandom_range(0, 3) == 0) begin
                hv = 1'b1;
                hd = 4'($urandom_range(0, 15));
            end
            step(hv, hv ? hd : 4'($urandom_range(0, 15)), acc);
            if (acc || (hv && $urandom_range(0, 7) == 0)) hv = 1'b0;
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                idle(2);
                rst = 1'b0;
            end
        end
        wild = 1'b0;
        idle(4);

        n_cmp++;
        if (n_cmp < 1000) begin
            n_bad++;
            $display("FAIL compare_count: got %0d, want at least 1000", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
